// File: rtl/input_cond_if.sv
// Bundles the per-channel inputs and conditioned outputs of input_cond.
//   en        : pulse enable from the controller
//   din       : raw asynchronous switch/button inputs
//   level     : debounced levels
//   pulse     : one-cycle edge/repeat pulses
//   any_pulse : OR of pulse
interface input_cond_if #(
  parameter int unsigned N = 8
);
  logic         en;
  logic [N-1:0] din;
  logic [N-1:0] level;
  logic [N-1:0] pulse;
  logic         any_pulse;

  modport master (output en, output din, input level, input pulse, input any_pulse);
  modport slave  (input en, input din, output level, output pulse, output any_pulse);
endinterface

// File: rtl/input_cond.sv
// Multi-channel input conditioner: per channel synchronise, debounce and emit
// a one-cycle pulse on the selected edge, with optional auto-repeat while held.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : slave side of input_cond_if (en, din in; level, pulse, any_pulse out)
module input_cond #(
  parameter int unsigned N             = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned MODE          = 0,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input_cond_if.slave   bus
);

  localparam int unsigned CW   = $clog2(DB_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);
  // Level at which the channel counts as "held" for auto-repeat
  localparam logic        ACT  = (MODE != 1);

  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0]                  level_q, level_d;
  logic [N-1:0]                  pulse_q, pulse_d;
  logic [N-1:0]                  arm_q, arm_d;
  logic [N-1:0]                  rep_q, rep_d;
  logic [N-1:0]                  edge_hit;
  logic [CW-1:0]                 cnt_q [N];
  logic [CW-1:0]                 cnt_d [N];
  logic [RW-1:0]                 rcnt_q [N];
  logic [RW-1:0]                 rcnt_d [N];

  // Next-state logic for synchroniser, debounce, edge detect and repeat
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.din};
    level_d  = level_q;
    pulse_d  = '0;
    arm_d    = '0;
    rep_d    = '0;
    edge_hit = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      rcnt_d[i] = '0;

      // Debounce: level follows sync only after DB_CYCLES of steady mismatch
      if (sync_q[SYNC_STAGES-1][i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
        level_d[i] = sync_q[SYNC_STAGES-1][i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end

      edge_hit[i] = (level_d[i] != level_q[i]) &&
                    ((MODE == 2) || (level_d[i] == (MODE == 0)));

      // Armed only after a real transition into the active level, so a
      // channel resting at the active level out of reset never repeats
      arm_d[i] = (level_d[i] == ACT) && (arm_q[i] || (level_q[i] != ACT));

      if (bus.en) begin
        if (edge_hit[i]) begin
          pulse_d[i] = 1'b1;
        end else if ((REPEAT_DELAY > 0) && arm_q[i] &&
                     (level_q[i] == ACT) && (level_d[i] == ACT)) begin
          if (!rep_q[i]) begin
            // Initial delay phase
            if (rcnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
              pulse_d[i] = 1'b1;
              rep_d[i]   = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end else begin
            // Periodic phase; with no period the counter parks at zero
            rep_d[i] = 1'b1;
            if (REPEAT_PERIOD > 0) begin
              if (rcnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
                pulse_d[i] = 1'b1;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
              end
            end
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= '0;
      level_q <= '0;
      pulse_q <= '0;
      arm_q   <= '0;
      rep_q   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      arm_q   <= arm_d;
      rep_q   <= rep_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  assign bus.level     = level_q;
  assign bus.pulse     = pulse_q;
  assign bus.any_pulse = |pulse_q;

endmodule

// File: tb/tb_input_cond.sv
// Scoreboard bench for input_cond: three instances (plain rising edge,
// both-edge, and auto-repeat) driven independently; expected pulse edges are
// queued when stimulus is applied and matched every cycle against the outputs.
module tb_input_cond;

  typedef struct {
    int         e;
    logic [1:0] m;
  } ev_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [1:0] din_a, din_b, din_c;
  int         edge_n = 0;
  int         total  = 0;
  int         bad    = 0;
  bit         mon_on = 1'b0;
  ev_t        q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  input_cond_if #(.N(2)) ia ();
  input_cond_if #(.N(2)) ib ();
  input_cond_if #(.N(2)) ic ();

  assign ia.en = en;  assign ia.din = din_a;
  assign ib.en = en;  assign ib.din = din_b;
  assign ic.en = en;  assign ic.din = din_c;

  input_cond #(.N(2), .SYNC_STAGES(2), .DB_CYCLES(4), .MODE(0),
               .REPEAT_DELAY(0), .REPEAT_PERIOD(0))
    dut_a (.clk(clk), .rstn(rstn), .bus(ia));

  input_cond #(.N(2), .SYNC_STAGES(2), .DB_CYCLES(4), .MODE(2),
               .REPEAT_DELAY(0), .REPEAT_PERIOD(0))
    dut_b (.clk(clk), .rstn(rstn), .bus(ib));

  input_cond #(.N(2), .SYNC_STAGES(2), .DB_CYCLES(1), .MODE(0),
               .REPEAT_DELAY(10), .REPEAT_PERIOD(4))
    dut_c (.clk(clk), .rstn(rstn), .bus(ic));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic ev_t mk_ev(input int e, input logic [1:0] m);
    ev_t x;
    x.e = e;
    x.m = m;
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic score(input string tag, input logic [1:0] p, input logic ap,
                       input bit hv, input ev_t f, output bit pop);
    pop = 1'b0;
    if (hv && f.e < edge_n) begin
      chk({tag, "_late"}, edge_n, f.e);
      pop = 1'b1;
    end else if (hv && f.e == edge_n) begin
      chk({tag, "_pulse"}, p, f.m);
      chk({tag, "_any"}, ap, (f.m != 2'b00));
      pop = 1'b1;
    end else begin
      chk({tag, "_idle"}, p, 0);
      chk({tag, "_any_idle"}, ap, 0);
    end
  endtask

  // Per-cycle scoreboard check, sampled mid-cycle
  ev_t f_m;
  bit  hv_m, pop_m;
  always @(negedge clk) begin
    if (mon_on) begin
      hv_m = (q_a.size() > 0); f_m = hv_m ? q_a[0] : mk_ev(0, 2'b00);
      score("a", ia.pulse, ia.any_pulse, hv_m, f_m, pop_m);
      if (pop_m) void'(q_a.pop_front());
      hv_m = (q_b.size() > 0); f_m = hv_m ? q_b[0] : mk_ev(0, 2'b00);
      score("b", ib.pulse, ib.any_pulse, hv_m, f_m, pop_m);
      if (pop_m) void'(q_b.pop_front());
      hv_m = (q_c.size() > 0); f_m = hv_m ? q_c[0] : mk_ev(0, 2'b00);
      score("c", ic.pulse, ic.any_pulse, hv_m, f_m, pop_m);
      if (pop_m) void'(q_c.pop_front());
    end
  end

  initial begin
    int e, r, fall;
    rstn  = 1'b0;
    en    = 1'b1;
    din_a = '0;
    din_b = '0;
    din_c = '0;
    tick(3);
    rstn = 1'b1;
    tick(1);
    mon_on = 1'b1;
    chk("rst_level_a", ia.level, 0);
    chk("rst_level_b", ib.level, 0);
    chk("rst_level_c", ic.level, 0);
    chk("rst_pulse_c", ic.pulse, 0);
    chk("rst_any_c",   ic.any_pulse, 0);

    // Basic rising edge: level/pulse at drive edge + SYNC + DB
    din_a = 2'b01;
    q_a.push_back(mk_ev(edge_n + 6, 2'b01));
    tick(10);
    chk("t1_level_high", ia.level, 2'b01);
    din_a = 2'b00;
    tick(10);
    chk("t1_level_low", ia.level, 2'b00);

    // Glitch of 3 cycles rejected; 4 cycles accepted
    din_a = 2'b01;
    tick(3);
    din_a = 2'b00;
    tick(12);
    chk("t2_glitch_level", ia.level, 2'b00);
    din_a = 2'b01;
    q_a.push_back(mk_ev(edge_n + 6, 2'b01));
    tick(4);
    din_a = 2'b00;
    tick(12);
    chk("t2_four_level", ia.level, 2'b00);

    // Both-edge mode, then simultaneous channels
    din_b = 2'b10;
    q_b.push_back(mk_ev(edge_n + 6, 2'b10));
    tick(20);
    chk("t3_press_level", ib.level, 2'b10);
    din_b = 2'b00;
    q_b.push_back(mk_ev(edge_n + 6, 2'b10));
    tick(20);
    chk("t3_release_level", ib.level, 2'b00);
    din_b = 2'b11;
    q_b.push_back(mk_ev(edge_n + 6, 2'b11));
    tick(10);
    chk("t3_both_level", ib.level, 2'b11);
    din_b = 2'b00;
    q_b.push_back(mk_ev(edge_n + 6, 2'b11));
    tick(10);

    // Auto-repeat: r, r+10, then every 4, none on the release edge
    e    = edge_n;
    r    = e + 3;
    fall = e + 33;
    din_c = 2'b01;
    q_c.push_back(mk_ev(r, 2'b01));
    for (int t = r + 10; t < fall; t += 4) q_c.push_back(mk_ev(t, 2'b01));
    tick(30);
    chk("t4_level_held", ic.level, 2'b01);
    din_c = 2'b00;
    tick(12);
    chk("t4_level_low", ic.level, 2'b00);

    // en gating: press lost, repeat starts REPEAT_DELAY after en rises
    en    = 1'b0;
    din_c = 2'b10;
    tick(10);
    chk("t5_level_gated", ic.level, 2'b10);
    tick(5);
    e  = edge_n;
    en = 1'b1;
    q_c.push_back(mk_ev(e + 10, 2'b10));
    q_c.push_back(mk_ev(e + 14, 2'b10));
    tick(15);
    din_c = 2'b00;
    tick(10);
    chk("t5_level_low", ic.level, 2'b00);

    // Async reset mid-repeat, then fresh pulse after release
    e     = edge_n;
    din_c = 2'b01;
    q_c.push_back(mk_ev(e + 3, 2'b01));
    q_c.push_back(mk_ev(e + 13, 2'b01));
    tick(17);
    chk("t6_repeat_before_rst", ic.pulse, 2'b01);
    #1;
    rstn = 1'b0;
    #1;
    chk("t6_rst_pulse", ic.pulse, 2'b00);
    chk("t6_rst_level", ic.level, 2'b00);
    chk("t6_rst_any",   ic.any_pulse, 0);
    tick(2);
    rstn = 1'b1;
    q_c.push_back(mk_ev(edge_n + 3, 2'b01));
    tick(5);
    chk("t6_level_rerise", ic.level, 2'b01);
    din_c = 2'b00;
    tick(12);
    chk("t6_level_low", ic.level, 2'b00);

    tick(5);
    chk("a_left", q_a.size(), 0);
    chk("b_left", q_b.size(), 0);
    chk("c_left", q_c.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
